// File: rtl/clock_disp_pkg.sv
// Shared constants for the six-digit HH:MM:SS multiplexed display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package clock_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned MS_LIMIT   = 60;
  localparam int unsigned HR_LIMIT   = 24;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [2:0] digit_idx_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clock_disp_bcd.sv
// Combinational split of a 7-bit binary field into decimal tens/ones,
// flagging values at or above LIMIT.
module clock_disp_bcd #(
  parameter int unsigned LIMIT = 60
) (
  input  logic [6:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       out_of_range
);

  always_comb begin
    tens         = 4'(value / 7'd10);
    ones         = 4'(value % 7'd10);
    out_of_range = (value >= 7'(LIMIT));
  end

endmodule

// File: rtl/clock_disp.sv
// Six-digit multiplexed seven-segment driver for a snapshot of HH:MM:SS.
// Digit 0 is seconds ones, digit 5 is hours tens; all outputs registered.
module clock_disp
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter bit          BLANK_HR0 = 1'b1
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       upd,
  input  logic [6:0] SC,
  input  logic [6:0] MT,
  input  logic [4:0] HR,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_sel
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  digit_idx_t      idx_q, idx_d;
  logic [6:0]      sc_q, mt_q;
  logic [4:0]      hr_q;
  logic [6:0]      seg_d;
  logic            dp_d;
  logic [5:0]      dig_sel_d;

  logic [3:0] sc_tens, sc_ones, mt_tens, mt_ones, hr_tens, hr_ones;
  logic       sc_oor, mt_oor, hr_oor;

  clock_disp_bcd #(.LIMIT(MS_LIMIT)) u_bcd_sc (
    .value        (sc_q),
    .tens         (sc_tens),
    .ones         (sc_ones),
    .out_of_range (sc_oor)
  );

  clock_disp_bcd #(.LIMIT(MS_LIMIT)) u_bcd_mt (
    .value        (mt_q),
    .tens         (mt_tens),
    .ones         (mt_ones),
    .out_of_range (mt_oor)
  );

  clock_disp_bcd #(.LIMIT(HR_LIMIT)) u_bcd_hr (
    .value        ({2'b00, hr_q}),
    .tens         (hr_tens),
    .ones         (hr_ones),
    .out_of_range (hr_oor)
  );

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = (idx_q == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : idx_q + 3'd1;
    end
  end

  // Output decode uses the pre-edge index so an index change shows one cycle later.
  always_comb begin
    seg_d     = SEG_BLANK;
    dp_d      = 1'b1;
    dig_sel_d = 6'b111111;
    unique case (idx_q)
      3'd0: begin
        dig_sel_d = 6'b111110;
        seg_d     = sc_oor ? SEG_DASH : seg_encode(sc_ones);
      end
      3'd1: begin
        dig_sel_d = 6'b111101;
        seg_d     = sc_oor ? SEG_DASH : seg_encode(sc_tens);
      end
      3'd2: begin
        dig_sel_d = 6'b111011;
        dp_d      = 1'b0;
        seg_d     = mt_oor ? SEG_DASH : seg_encode(mt_ones);
      end
      3'd3: begin
        dig_sel_d = 6'b110111;
        seg_d     = mt_oor ? SEG_DASH : seg_encode(mt_tens);
      end
      3'd4: begin
        dig_sel_d = 6'b101111;
        dp_d      = 1'b0;
        seg_d     = hr_oor ? SEG_DASH : seg_encode(hr_ones);
      end
      3'd5: begin
        dig_sel_d = 6'b011111;
        if (hr_oor) begin
          seg_d = SEG_DASH;
        end else if (BLANK_HR0 && (hr_tens == 4'd0)) begin
          seg_d = SEG_BLANK;
        end else begin
          seg_d = seg_encode(hr_tens);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      sc_q    <= '0;
      mt_q    <= '0;
      hr_q    <= '0;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
      dig_sel <= 6'b111111;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg     <= seg_d;
      dp      <= dp_d;
      dig_sel <= dig_sel_d;
      if (upd) begin
        sc_q <= SC;
        mt_q <= MT;
        hr_q <= HR;
      end
    end
  end

endmodule

// File: tb/tb_clock_disp.sv
// Directed bench: a SCAN_DIV=4 instance for frame-level checks and a
// SCAN_DIV=1 instance for the per-cycle index/snapshot race.
module tb_clock_disp;

  logic       clk;
  logic       rst_n;
  logic       upd4, upd1;
  logic [6:0] sc, mt;
  logic [4:0] hr;
  logic [6:0] seg4, seg1;
  logic       dp4, dp1;
  logic [5:0] dig4, dig1;

  int n_checks = 0;
  int n_fail   = 0;

  clock_disp #(.SCAN_DIV(4), .BLANK_HR0(1'b1)) dut4 (
    .clk_50  (clk),
    .rst_n   (rst_n),
    .upd     (upd4),
    .SC      (sc),
    .MT      (mt),
    .HR      (hr),
    .seg     (seg4),
    .dp      (dp4),
    .dig_sel (dig4)
  );

  clock_disp #(.SCAN_DIV(1), .BLANK_HR0(1'b1)) dut1 (
    .clk_50  (clk),
    .rst_n   (rst_n),
    .upd     (upd1),
    .SC      (sc),
    .MT      (mt),
    .HR      (hr),
    .seg     (seg1),
    .dp      (dp1),
    .dig_sel (dig1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0-9 digits, 10 = dash, 11 = blank
  function automatic logic [6:0] code(input int v);
    case (v)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      10:      return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    upd4  = 1'b0;
    upd1  = 1'b0;
    sc    = '0;
    mt    = '0;
    hr    = '0;
    @(posedge clk); #1;
    n_checks++;
    if (seg4 !== 7'h7F) begin
      n_fail++; $display("FAIL reset_seg got %b want %b", seg4, 7'h7F);
    end
    n_checks++;
    if (dp4 !== 1'b1) begin
      n_fail++; $display("FAIL reset_dp got %b want 1", dp4);
    end
    n_checks++;
    if (dig4 !== 6'b111111) begin
      n_fail++; $display("FAIL reset_dig_sel got %b want 111111", dig4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int exp_v [6];
    exp_v = '{0, 0, 0, 0, 0, 11};
    for (int k = 0; k < 24; k++) begin
      int d;
      logic [5:0] es;
      d  = k / 4;
      es = ~(6'b000001 << d);
      @(posedge clk); #1;
      n_checks++;
      if (dig4 !== es) begin
        n_fail++; $display("FAIL scan_dig_sel k=%0d got %b want %b", k, dig4, es);
      end
      n_checks++;
      if (seg4 !== code(exp_v[d])) begin
        n_fail++; $display("FAIL scan_seg k=%0d got %b want %b", k, seg4, code(exp_v[d]));
      end
      n_checks++;
      if (dp4 !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL scan_dp k=%0d got %b", k, dp4);
      end
    end
  endtask

  // Captures a new snapshot on the first edge of the frame, then checks the rest.
  task automatic test_frame(input string name, input logic do_upd, input logic [6:0] s,
                            input logic [6:0] m, input logic [4:0] h, input int e0,
                            input int e1, input int e2, input int e3, input int e4,
                            input int e5);
    int exp_v [6];
    exp_v = '{e0, e1, e2, e3, e4, e5};
    sc   = s;
    mt   = m;
    hr   = h;
    upd4 = do_upd;
    for (int k = 0; k < 24; k++) begin
      int d;
      logic [5:0] es;
      d  = k / 4;
      es = ~(6'b000001 << d);
      @(posedge clk); #1;
      upd4 = 1'b0;
      if (!(do_upd && k == 0)) begin
        n_checks++;
        if (dig4 !== es) begin
          n_fail++; $display("FAIL %s_dig_sel k=%0d got %b want %b", name, k, dig4, es);
        end
        n_checks++;
        if (seg4 !== code(exp_v[d])) begin
          n_fail++;
          $display("FAIL %s_seg k=%0d got %b want %b", name, k, seg4, code(exp_v[d]));
        end
      end
    end
  endtask

  task automatic test_snapshot();
    test_frame("snapshot", 1'b1, 7'd59, 7'd7, 5'd23, 9, 5, 7, 0, 3, 2);
  endtask

  task automatic test_no_upd();
    test_frame("no_upd", 1'b0, 7'd12, 7'd34, 5'd5, 9, 5, 7, 0, 3, 2);
  endtask

  task automatic test_out_of_range();
    test_frame("oor", 1'b1, 7'd60, 7'd0, 5'd24, 10, 10, 0, 0, 10, 10);
  endtask

  task automatic test_blank_hr();
    test_frame("blank_hr", 1'b1, 7'd30, 7'd45, 5'd9, 0, 3, 5, 4, 9, 11);
  endtask

  task automatic test_reset_mid();
    repeat (14) @(posedge clk);
    #1;
    n_checks++;
    if (dig4 !== 6'b110111) begin
      n_fail++; $display("FAIL mid_pre_dig_sel got %b want 110111", dig4);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (seg4 !== 7'h7F || dp4 !== 1'b1 || dig4 !== 6'b111111) begin
      n_fail++; $display("FAIL mid_async got seg=%b dp=%b dig=%b want 1111111/1/111111",
                         seg4, dp4, dig4);
    end
    @(posedge clk); #1;
    n_checks++;
    if (seg4 !== 7'h7F || dig4 !== 6'b111111) begin
      n_fail++; $display("FAIL mid_held got seg=%b dig=%b", seg4, dig4);
    end
    rst_n = 1'b1;
    test_frame("mid_restart", 1'b0, 7'd30, 7'd45, 5'd9, 0, 0, 0, 0, 0, 11);
  endtask

  task automatic test_back_to_back();
    int old_v [6];
    int new_v [6];
    old_v = '{0, 0, 0, 0, 0, 11};
    new_v = '{0, 0, 0, 0, 7, 1};
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sc = 7'd0;
    mt = 7'd0;
    hr = 5'd17;
    for (int e = 1; e <= 12; e++) begin
      int d;
      logic [5:0] es;
      logic [6:0] eseg;
      upd1 = (e == 5);
      @(posedge clk); #1;
      d    = (e - 1) % 6;
      es   = ~(6'b000001 << d);
      eseg = code((e >= 6) ? new_v[d] : old_v[d]);
      n_checks++;
      if (dig1 !== es) begin
        n_fail++; $display("FAIL fast_dig_sel e=%0d got %b want %b", e, dig1, es);
      end
      n_checks++;
      if ($countones(~dig1) != 1) begin
        n_fail++; $display("FAIL fast_one_cold e=%0d got %b want one low bit", e, dig1);
      end
      n_checks++;
      if (seg1 !== eseg) begin
        n_fail++; $display("FAIL fast_seg e=%0d got %b want %b", e, seg1, eseg);
      end
    end
    upd1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_no_upd();
    test_out_of_range();
    test_blank_hr();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
